// File: rtl/ncc_pkg.sv
// Shared definitions for the NCC descriptor byte link (transmit side and PCI descriptor loader).
package ncc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        CSUM    = 2'd3
    } state_t;

    localparam logic [7:0] SOF_BYTE = 8'hA5;

endpackage

// File: rtl/byte_shifter.sv
// Parallel-load register that shifts left by one byte; the top byte is always visible on msbByte.
module byte_shifter
    import ncc_pkg::*;
#(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [w-1:0] in,
    output logic [7:0]   msbByte
);

    logic [w-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= in;
        end else if (shift) begin
            q <= q << 8;
        end
    end

    assign msbByte = q[w-1 -: 8];

endmodule

// File: rtl/desc_tx.sv
// Descriptor transmitter: serialises one descriptor as SOF, payload bytes MSB-first, then an 8-bit checksum.
module desc_tx
    import ncc_pkg::*;
#(
    parameter int         descSize = 2048,
    parameter logic [7:0] SOF      = SOF_BYTE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [descSize-1:0] descIn,
    input  logic                descValid,
    output logic                descReady,
    output logic [7:0]          pciOut,
    output logic                pciOutValid,
    input  logic                pciOutReady,
    output logic                busy,
    output logic                done
);

    localparam int numBytes = descSize / 8;
    localparam int CW       = $clog2(numBytes + 1);

    state_t        state;
    logic [CW-1:0] count;
    logic [7:0]    csum;
    logic [7:0]    msbByte;
    logic          in_xfer;
    logic          out_xfer;
    logic          shift_en;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    assign descReady = (state == IDLE);
    assign busy      = (state != IDLE);
    assign in_xfer   = descValid && descReady;
    assign out_xfer  = pciOutValid && pciOutReady;

    // The shifter advances as each byte is moved into pciOut, so msbByte already
    // presents the following payload byte while the current one waits downstream.
    assign shift_en  = out_xfer && ((state == HDR) || (state == PAYLOAD));

    byte_shifter #(.w(descSize)) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (in_xfer),
        .shift   (shift_en),
        .in      (descIn),
        .msbByte (msbByte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pciOut      <= 8'h00;
            pciOutValid <= 1'b0;
            done        <= 1'b0;
            csum        <= 8'h00;
            count       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        csum        <= 8'h00;
                        count       <= CW'(numBytes);
                        pciOut      <= SOF;
                        pciOutValid <= 1'b1;
                        state       <= HDR;
                    end
                end
                HDR: begin
                    if (out_xfer) begin
                        pciOut <= msbByte;
                        state  <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (out_xfer) begin
                        csum  <= csum_add(csum, pciOut);
                        count <= count - 1'b1;
                        if (count == CW'(1)) begin
                            pciOut <= csum_add(csum, pciOut);
                            state  <= CSUM;
                        end else begin
                            pciOut <= msbByte;
                        end
                    end
                end
                CSUM: begin
                    if (out_xfer) begin
                        pciOutValid <= 1'b0;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
